wash_cycle_controller: RTL and testbench

- Sequences one coin-paid laundry cycle (fill, wash, rinse, spin) for the mode that Mode_Select produces.
- Latches the one-hot Mode on Start and steps through phases timed by a one-second prescaler.
- Drives valve, motor and drain outputs, and feeds isRunning back to Mode_Select so the mode cannot change mid-cycle.

---
 rtl/wash_pkg.sv | 89 ++++++++
 rtl/sec_timer.sv | 57 +++++
 rtl/wash_cycle_controller.sv | 156 +++++++++++++++
 tb/tb_wash_cycle_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle controller: phase encodings, mode
// constants and the per-mode phase-duration table.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DONE  = 3'd5,
    PH_PAUSE = 3'd6
  } phase_e;

  localparam logic [3:0] MODE_LIGHT  = 4'b0001;
  localparam logic [3:0] MODE_NORMAL = 4'b0010;
  localparam logic [3:0] MODE_HEAVY  = 4'b0100;
  localparam logic [3:0] MODE_SPIN   = 4'b1000;

  function automatic logic is_one_hot(input logic [3:0] mode);
    logic ok;
    case (mode)
      MODE_LIGHT, MODE_NORMAL, MODE_HEAVY, MODE_SPIN: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Seconds spent in a timed phase; non-timed phases and unknown modes are 0.
  function automatic logic [4:0] phase_secs(input logic [3:0] mode, input phase_e ph);
    logic [4:0] s;
    s = 5'd0;
    case (mode)
      MODE_LIGHT: begin
        case (ph)
          PH_FILL:  s = 5'd2;
          PH_WASH:  s = 5'd3;
          PH_RINSE: s = 5'd2;
          PH_SPIN:  s = 5'd2;
          default:  s = 5'd0;
        endcase
      end
      MODE_NORMAL: begin
        case (ph)
          PH_FILL:  s = 5'd2;
          PH_WASH:  s = 5'd5;
          PH_RINSE: s = 5'd3;
          PH_SPIN:  s = 5'd3;
          default:  s = 5'd0;
        endcase
      end
      MODE_HEAVY: begin
        case (ph)
          PH_FILL:  s = 5'd2;
          PH_WASH:  s = 5'd8;
          PH_RINSE: s = 5'd4;
          PH_SPIN:  s = 5'd4;
          default:  s = 5'd0;
        endcase
      end
      MODE_SPIN: begin
        case (ph)
          PH_SPIN:  s = 5'd4;
          default:  s = 5'd0;
        endcase
      end
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  // First timed phase after ph whose duration is nonzero, else DONE.
  function automatic phase_e next_run_phase(input logic [3:0] mode, input phase_e ph);
    phase_e nxt;
    if (ph < PH_FILL && phase_secs(mode, PH_FILL) != 5'd0) begin
      nxt = PH_FILL;
    end else if (ph < PH_WASH && phase_secs(mode, PH_WASH) != 5'd0) begin
      nxt = PH_WASH;
    end else if (ph < PH_RINSE && phase_secs(mode, PH_RINSE) != 5'd0) begin
      nxt = PH_RINSE;
    end else if (ph < PH_SPIN && phase_secs(mode, PH_SPIN) != 5'd0) begin
      nxt = PH_SPIN;
    end else begin
      nxt = PH_DONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// One-second prescaler plus per-phase seconds down-counter. Loading a zero
// value clears both counters.
module sec_timer
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             enable,
  output logic [SEC_W-1:0] sec_left,
  output logic             expire
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] presc_d, presc_q;
  logic [SEC_W-1:0] sec_d, sec_q;

  // Counter update: load wins over counting
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (load) begin
      sec_d   = load_value;
      presc_d = (load_value == {SEC_W{1'b0}}) ? {PRE_W{1'b0}} : PRE_MAX;
    end else if (enable) begin
      if (presc_q == {PRE_W{1'b0}}) begin
        presc_d = PRE_MAX;
        sec_d   = sec_q - SEC_W'(1);
      end else begin
        presc_d = presc_q - PRE_W'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= {PRE_W{1'b0}};
      sec_q   <= {SEC_W{1'b0}};
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  assign sec_left = sec_q;
  assign expire   = (presc_q == {PRE_W{1'b0}}) && (sec_q == SEC_W'(1));

endmodule

// File: rtl/wash_cycle_controller.sv
// Coin-laundry cycle sequencer: fill, wash, rinse, spin for a latched one-hot
// mode, with door-interlock pause and abort. Outputs are registered.
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int SEC_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Mode,
  input  logic             Start,
  input  logic             DoorClosed,
  input  logic             Abort,
  output logic             isRunning,
  output logic [2:0]       Phase,
  output logic [SEC_W-1:0] SecLeft,
  output logic             WaterValve,
  output logic             Motor,
  output logic             DrainPump,
  output logic             Done
);

  phase_e state_d, state_q;
  phase_e saved_d, saved_q;
  logic [3:0] mode_d, mode_q;

  logic             t_load, t_enable, t_expire;
  logic [SEC_W-1:0] t_value;

  logic running_d, running_q, valve_d, valve_q;
  logic motor_d, motor_q, drain_d, drain_q, done_d, done_q;

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .SEC_W        (SEC_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (t_load),
    .load_value(t_value),
    .enable    (t_enable),
    .sec_left  (SecLeft),
    .expire    (t_expire)
  );

  // Next state: start qualification, then abort > door > timer in running phases
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    mode_d   = mode_q;
    t_load   = 1'b0;
    t_value  = {SEC_W{1'b0}};
    t_enable = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (Start && DoorClosed && !Abort && is_one_hot(Mode)) begin
          mode_d  = Mode;
          state_d = next_run_phase(Mode, PH_IDLE);
          t_load  = 1'b1;
          t_value = SEC_W'(phase_secs(Mode, state_d));
        end else begin
          state_d = PH_IDLE;
        end
      end
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
        if (Abort) begin
          state_d = PH_IDLE;
          t_load  = 1'b1;
        end else if (!DoorClosed) begin
          saved_d = state_q;
          state_d = PH_PAUSE;
        end else if (t_expire) begin
          state_d = next_run_phase(mode_q, state_q);
          t_load  = 1'b1;
          t_value = SEC_W'(phase_secs(mode_q, state_d));
        end else begin
          t_enable = 1'b1;
        end
      end
      PH_PAUSE: begin
        if (Abort) begin
          state_d = PH_IDLE;
          t_load  = 1'b1;
        end else if (DoorClosed) begin
          state_d = saved_q;
        end else begin
          state_d = PH_PAUSE;
        end
      end
      PH_DONE: state_d = PH_IDLE;
      default: begin
        state_d = PH_IDLE;
        t_load  = 1'b1;
      end
    endcase
  end

  // Actuator decode from the next state so outputs line up with Phase
  always_comb begin
    running_d = 1'b0;
    valve_d   = 1'b0;
    motor_d   = 1'b0;
    drain_d   = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      PH_FILL: begin
        running_d = 1'b1;
        valve_d   = 1'b1;
      end
      PH_WASH: begin
        running_d = 1'b1;
        motor_d   = 1'b1;
      end
      PH_RINSE, PH_SPIN: begin
        running_d = 1'b1;
        motor_d   = 1'b1;
        drain_d   = 1'b1;
      end
      PH_PAUSE: running_d = 1'b1;
      PH_DONE:  done_d    = 1'b1;
      default:  running_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PH_IDLE;
      saved_q   <= PH_IDLE;
      mode_q    <= 4'b0000;
      running_q <= 1'b0;
      valve_q   <= 1'b0;
      motor_q   <= 1'b0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      mode_q    <= mode_d;
      running_q <= running_d;
      valve_q   <= valve_d;
      motor_q   <= motor_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
    end
  end

  assign Phase      = state_q;
  assign isRunning  = running_q;
  assign WaterValve = valve_q;
  assign Motor      = motor_q;
  assign DrainPump  = drain_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: directed table, hand-written corner
// sequences, and randomized stimulus against a cycles-remaining model.
module tb_wash_cycle_controller;

  localparam int TPS = 4;
  localparam int SW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    Mode = 4'b0000;
  logic          Start = 1'b0;
  logic          DoorClosed = 1'b1;
  logic          Abort = 1'b0;
  logic          isRunning, WaterValve, Motor, DrainPump, Done;
  logic [2:0]    Phase;
  logic [SW-1:0] SecLeft;

  int passed = 0;
  int total  = 0;

  wash_cycle_controller #(.TICKS_PER_SEC(TPS), .SEC_W(SW)) dut (
    .clk(clk), .rst(rst), .Mode(Mode), .Start(Start), .DoorClosed(DoorClosed),
    .Abort(Abort), .isRunning(isRunning), .Phase(Phase), .SecLeft(SecLeft),
    .WaterValve(WaterValve), .Motor(Motor), .DrainPump(DrainPump), .Done(Done)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles left in the phase, latched mode.
  int         m_ph    = 0;
  int         m_left  = 0;
  int         m_saved = 0;
  logic [3:0] m_mode  = 4'b0000;

  function automatic int dur(input logic [3:0] m, input int ph);
    int tab [4];
    case (m)
      4'b0001: tab = '{2, 3, 2, 2};
      4'b0010: tab = '{2, 5, 3, 3};
      4'b0100: tab = '{2, 8, 4, 4};
      4'b1000: tab = '{0, 0, 0, 4};
      default: tab = '{0, 0, 0, 0};
    endcase
    return tab[ph-1];
  endfunction

  task automatic enter_after(input int p);
    bit found = 1'b0;
    for (int q = p + 1; q <= 4; q++) begin
      if (!found && dur(m_mode, q) != 0) begin
        found  = 1'b1;
        m_ph   = q;
        m_left = dur(m_mode, q) * TPS;
      end
    end
    if (!found) begin
      m_ph   = 5;
      m_left = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_ph = 0; m_left = 0; m_mode = 4'b0000;
    end else begin
      case (m_ph)
        0: if (Start && DoorClosed && !Abort && $onehot(Mode)) begin
             m_mode = Mode;
             enter_after(0);
           end
        1, 2, 3, 4: begin
          if (Abort) begin
            m_ph = 0; m_left = 0;
          end else if (!DoorClosed) begin
            m_saved = m_ph; m_ph = 6;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) enter_after(m_ph);
          end
        end
        5: m_ph = 0;
        6: begin
          if (Abort) begin
            m_ph = 0; m_left = 0;
          end else if (DoorClosed) begin
            m_ph = m_saved;
          end
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  // {isRunning, WaterValve, Motor, DrainPump, Done} for a phase number
  function automatic logic [4:0] outs_for(input int ph);
    case (ph)
      1:       return 5'b11000;
      2:       return 5'b10100;
      3, 4:    return 5'b10110;
      5:       return 5'b00001;
      6:       return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] dut_outs();
    return {isRunning, WaterValve, Motor, DrainPump, Done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    int exp_sec;
    @(posedge clk);
    model_step();
    #1;
    exp_sec = ((m_ph >= 1 && m_ph <= 4) || m_ph == 6) ? (m_left + TPS - 1) / TPS : 0;
    check("model_phase", 32'(Phase), 32'(m_ph));
    check("model_secleft", 32'(SecLeft), 32'(exp_sec));
    check("model_outputs", 32'(dut_outs()), 32'(outs_for(m_ph)));
  endtask

  task automatic do_reset();
    rst = 1'b1; Start = 1'b0; Abort = 1'b0; DoorClosed = 1'b1; Mode = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] m);
    Mode = m; Start = 1'b1; DoorClosed = 1'b1; Abort = 1'b0;
    tick();
    Start = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] mode;
    logic       start;
    logic       door;
    logic       abort;
    logic [2:0] ph;
    logic [4:0] sec;
    logic [4:0] outs;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int j;
    int exp_ph;

    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'b00000};
    vecs[1]  = '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'b00000};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 5'b00000};
    vecs[3]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'b00000};
    vecs[4]  = '{1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 3'd0, 5'd0, 5'b00000};
    vecs[5]  = '{1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd4, 5'd4, 5'b10110};
    vecs[6]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd4, 5'd4, 5'b10110};
    vecs[7]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd6, 5'd4, 5'b10000};
    vecs[8]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd4, 5'd4, 5'b10110};
    vecs[9]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 3'd0, 5'd0, 5'b00000};
    vecs[10] = '{1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd1, 5'd2, 5'b11000};
    vecs[11] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 5'b00000};

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; Mode = vecs[i].mode; Start = vecs[i].start;
      DoorClosed = vecs[i].door; Abort = vecs[i].abort;
      tick();
      check($sformatf("vec%0d_phase", i), 32'(Phase), 32'(vecs[i].ph));
      check($sformatf("vec%0d_sec", i), 32'(SecLeft), 32'(vecs[i].sec));
      check($sformatf("vec%0d_outs", i), 32'(dut_outs()), 32'(vecs[i].outs));
    end

    // Light: phase boundaries relative to the Start edge
    do_reset();
    start_run(4'b0001);
    for (int k = 0; k < 38; k++) begin
      exp_ph = (k < 8) ? 1 : (k < 20) ? 2 : (k < 28) ? 3 : (k < 36) ? 4 : (k == 36) ? 5 : 0;
      if (k == 0 || k == 7 || k == 8 || k == 19 || k == 20 || k == 27 ||
          k == 28 || k == 35 || k == 36 || k == 37) begin
        check($sformatf("light_phase_k%0d", k), 32'(Phase), 32'(exp_ph));
        check($sformatf("light_outs_k%0d", k), 32'(dut_outs()), 32'(outs_for(exp_ph)));
      end
      tick();
    end

    // Heavy with a 10-cycle door-open interval mid-WASH
    do_reset();
    start_run(4'b0100);
    repeat (20) tick();
    check("heavy_sec_before_pause", 32'(SecLeft), 32'd5);
    DoorClosed = 1'b0;
    repeat (10) tick();
    check("heavy_pause_phase", 32'(Phase), 32'd6);
    check("heavy_pause_motor", 32'(Motor), 32'd0);
    check("heavy_pause_sec", 32'(SecLeft), 32'd5);
    DoorClosed = 1'b1;
    tick();
    check("heavy_resume_phase", 32'(Phase), 32'd2);
    check("heavy_resume_sec", 32'(SecLeft), 32'd5);
    j = 31;
    while (Done !== 1'b1 && j < 200) begin
      tick();
      j++;
    end
    check("heavy_done_cycle", 32'(j), 32'd83);

    // Normal, abort during RINSE
    do_reset();
    start_run(4'b0010);
    repeat (30) tick();
    check("abort_pre_phase", 32'(Phase), 32'd3);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_phase", 32'(Phase), 32'd0);
    check("abort_outs", 32'(dut_outs()), 32'd0);
    check("abort_sec", 32'(SecLeft), 32'd0);
    tick();
    check("abort_no_done", 32'(Done), 32'd0);

    // Normal with Mode toggled mid-WASH, then reset during SPIN
    do_reset();
    start_run(4'b0010);
    repeat (10) tick();
    Mode = 4'b0100;
    repeat (17) tick();
    check("toggle_wash_end", 32'(Phase), 32'd2);
    tick();
    check("toggle_rinse_start", 32'(Phase), 32'd3);
    repeat (17) tick();
    check("toggle_spin", 32'(Phase), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_spin_phase", 32'(Phase), 32'd0);
    check("rst_spin_outs", 32'(dut_outs()), 32'd0);
    check("rst_spin_sec", 32'(SecLeft), 32'd0);

    // SpinOnly with Start held through DONE
    do_reset();
    Mode = 4'b1000; Start = 1'b1;
    tick();
    check("spin_first_phase", 32'(Phase), 32'd4);
    check("spin_first_sec", 32'(SecLeft), 32'd4);
    repeat (16) tick();
    check("spin_done", 32'(dut_outs()), 32'b00001);
    tick();
    check("spin_idle", 32'(Phase), 32'd0);
    tick();
    check("spin_restart", 32'(Phase), 32'd4);
    Start = 1'b0;

    // Randomized stimulus against the model
    do_reset();
    for (int r = 0; r < 3000; r++) begin
      rst        = ($urandom_range(0, 199) == 0);
      Abort      = ($urandom_range(0, 59) == 0);
      DoorClosed = ($urandom_range(0, 24) != 0);
      Start      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        Mode = 4'b0001 << $urandom_range(0, 3);
      end else begin
        Mode = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
